// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
// Holds the per-channel state encoding and a counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_PEND_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_PEND_LOW  = 2'b11
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchronizer, qualification FSM and
// registered level / edge-pulse outputs.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic tick,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          sync;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          out_nx;

    // Two-flop synchronizer for the raw asynchronous input.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1   <= 1'b0;
            sync <= 1'b0;
        end else begin
            s1   <= button;
            sync <= s1;
        end
    end

    // State, qualification counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_LOW;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            out   <= out_nx;
            rise  <= out_nx & ~out;
            fall  <= ~out_nx & out;
        end
    end

    // Next state: a revert of sync always beats a coincident tick.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_LOW: begin
                if (sync) begin
                    state_nx = ST_PEND_HIGH;
                    cnt_nx   = '0;
                end
            end
            ST_PEND_HIGH: begin
                if (!sync) begin
                    state_nx = ST_LOW;
                end else if (tick) begin
                    if (cnt == LAST) state_nx = ST_HIGH;
                    else             cnt_nx   = cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!sync) begin
                    state_nx = ST_PEND_LOW;
                    cnt_nx   = '0;
                end
            end
            ST_PEND_LOW: begin
                if (sync) begin
                    state_nx = ST_HIGH;
                end else if (tick) begin
                    if (cnt == LAST) state_nx = ST_LOW;
                    else             cnt_nx   = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // Level is held through PEND_LOW so release is filtered like press.
    always_comb begin
        out_nx = (state_nx == ST_HIGH) || (state_nx == ST_PEND_LOW);
    end

endmodule

// File: rtl/multi_debouncer.sv
// Debouncer for a bank of buttons sharing one sample-tick generator.
// Each channel is an independent debounce_channel instance.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_CYCLES  = 500000,
    parameter int STABLE_TICKS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int TW = cnt_width(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TICK_LAST);

    // Free-running sample tick counter, wraps after TICK_CYCLES.
    always_ff @(posedge clock) begin
        if (reset)     tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .button(button[i]),
            .tick  (tick),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios plus random stimulus,
// checked every cycle against a level/streak reference model.
module tb_multi_debouncer;

    localparam int CH = 4;
    localparam int T  = 4;
    localparam int S  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] button = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    multi_debouncer #(
        .CHANNELS(CH),
        .TICK_CYCLES(T),
        .STABLE_TICKS(S)
    ) dut (
        .clock (clock),
        .reset (reset),
        .button(button),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Reference model. e = index of clock edges since reset release.
    // sync at edge e equals button sampled at edge e-2. A tick is seen
    // at edge e when e mod T == T-1. A channel flips its level once sync
    // has disagreed with it at every edge from ds onward and S ticks
    // fell in the edges (ds, e].
    int            e = 0;
    int            ds[CH];
    logic [CH-1:0] m_out  = '0;
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_fall = '0;
    logic [CH-1:0] p1 = '0;
    logic [CH-1:0] p2 = '0;
    logic [CH-1:0] m_sync;
    bit            live = 0;

    always @(posedge clock) begin
        if (reset) begin
            e = 0;
            m_out = '0;
            m_rise = '0;
            m_fall = '0;
            p1 = '0;
            p2 = '0;
            for (int i = 0; i < CH; i++) ds[i] = -1;
            live = 1;
        end else begin
            m_sync = p2;
            p2 = p1;
            p1 = button;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < CH; i++) begin
                if (m_sync[i] == m_out[i]) begin
                    ds[i] = -1;
                end else if (ds[i] < 0) begin
                    ds[i] = e;
                end else if ((e + 1) / T - (ds[i] + 1) / T == S) begin
                    m_out[i]  = m_sync[i];
                    m_rise[i] = m_sync[i];
                    m_fall[i] = !m_sync[i];
                    ds[i] = -1;
                end
            end
            e++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (live) begin
            chk("out", out, m_out);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("rise_fall_excl", int'(|(rise & fall)), 0);
        end
    end

    int            rise_cnt[CH];
    int            fall_cnt[CH];
    int            rise_edge[CH];
    logic [CH-1:0] first_rise;
    int            p;
    int            seg[CH];

    task automatic clr();
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i]  = 0;
            fall_cnt[i]  = 0;
            rise_edge[i] = -1;
        end
        first_rise = '0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clock);
            for (int i = 0; i < CH; i++) begin
                if (rise[i]) begin
                    rise_cnt[i]++;
                    if (rise_edge[i] < 0) rise_edge[i] = e - 1;
                end
                if (fall[i]) fall_cnt[i]++;
            end
            if (first_rise == '0) first_rise = rise;
        end
    endtask

    initial begin
        reset  = 1'b1;
        button = 4'hF;
        clr();
        run(3);
        chk("reset_out", out, 0);
        chk("reset_rise", rise_cnt[0] + rise_cnt[3], 0);
        chk("reset_fall", fall, 0);

        reset = 1'b0;
        p = e;
        clr();
        run(20);
        chk("release_lat_ch0", rise_edge[0] - p, 11);
        for (int i = 0; i < CH; i++) begin
            chk_rng("release_lat", rise_edge[i] - p, 11, 14);
            chk("release_rises", rise_cnt[i], 1);
        end
        chk("release_vec", first_rise, 4'hF);

        button = '0;
        run(20);
        chk("all_released", out, 0);

        button = 4'b0001;
        p = e;
        clr();
        run(20);
        chk_rng("press_lat_ch0", rise_edge[0] - p, 11, 14);
        chk("press_rise_ch0", rise_cnt[0], 1);
        chk("press_fall_ch0", fall_cnt[0], 0);
        chk("press_out_ch0", out[0], 1);

        clr();
        for (int k = 0; k < 10; k++) begin
            button[1] = (k % 2 == 0);
            run(3);
        end
        chk("bounce_no_rise", rise_cnt[1], 0);
        button[1] = 1'b1;
        p = e;
        clr();
        run(20);
        chk("bounce_one_rise", rise_cnt[1], 1);
        chk_rng("bounce_lat", rise_edge[1] - p, 11, 14);

        button[2] = 1'b1;
        run(20);
        chk("glitch_pressed", out[2], 1);
        clr();
        button[2] = 1'b0;
        run(5);
        button[2] = 1'b1;
        run(20);
        chk("glitch_no_fall", fall_cnt[2], 0);
        chk("glitch_held", out[2], 1);
        clr();
        button[2] = 1'b0;
        run(20);
        chk("glitch_one_fall", fall_cnt[2], 1);
        chk("glitch_low", out[2], 0);

        button[0] = 1'b0;
        button[3] = 1'b0;
        run(20);
        clr();
        button[0] = 1'b1;
        button[3] = 1'b1;
        run(20);
        chk("simul_vec", first_rise, 4'b1001);
        chk("simul_ch1_quiet", rise_cnt[1] + fall_cnt[1], 0);
        chk("simul_ch2_quiet", rise_cnt[2] + fall_cnt[2], 0);
        chk("simul_out", out, 4'b1011);

        button[0] = 1'b0;
        run(20);
        clr();
        button[0] = 1'b1;
        run(6);
        chk("mid_pending_out", out[0], 0);
        reset = 1'b1;
        run(2);
        chk("mid_reset_out", out, 0);
        chk("mid_reset_rise", rise_cnt[0], 0);
        reset = 1'b0;
        p = e;
        clr();
        run(20);
        chk("mid_requal_lat", rise_edge[0] - p, 11);
        chk("mid_requal_rise", rise_cnt[0], 1);

        for (int i = 0; i < CH; i++) seg[i] = 0;
        repeat (3000) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < CH; i++) begin
                if (seg[i] == 0) begin
                    button[i] = 1'($urandom);
                    seg[i] = ($urandom_range(0, 3) == 0)
                           ? $urandom_range(1, 4)
                           : $urandom_range(5, 30);
                end
                seg[i]--;
            end
            run(1);
        end
        reset = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
